sram_port_arbiter: RTL and testbench

// - Shares sram_single_port between two requesters: port 0 is the memory interface unit
//   (instruction-driven load/store); port 1 is a test/preload master that fills or dumps

---
 rtl/sram_port_arbiter_pkg.sv | 6 +
 rtl/sram_port_arbiter_rr_pick.sv | 10 +
 rtl/sram_port_arbiter.sv | 129 ++++++++++++
 tb/tb_sram_port_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// sram_port_arbiter_pkg: shared types and widths for the SRAM port arbiter
package sram_port_arbiter_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_RESP} arb_state_t;
  typedef enum logic {MEM_RD, MEM_WR} mem_op_t;
  localparam int SRAM_ADDR_W = 14;
endpackage

// File: rtl/sram_port_arbiter_rr_pick.sv
// sram_rr_pick: combinational two-way round-robin pick, ptr breaks ties
module sram_rr_pick (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       gnt_valid,
  output logic       gnt_id
);
  assign gnt_valid = |req;
  assign gnt_id    = &req ? ptr : req[1];
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: round-robin sharing of one SRAM port between two requesters, one transaction at a time
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W      = SRAM_ADDR_W,
  parameter int WDATA_W     = 16,
  parameter int RDATA_W     = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [1:0]             rd_req,
  input  logic [1:0]             wr_req,
  input  logic [1:0][ADDR_W-1:0] addr_in,
  input  logic [1:0][WDATA_W-1:0] wdata_in,
  output logic [1:0]             done,
  output logic [1:0]             err,
  output logic [RDATA_W-1:0]     rdata_out,
  output logic                   grant_id,
  output logic                   busy,
  output logic                   sram_re,
  output logic                   sram_we,
  output logic [ADDR_W-1:0]      sram_addr,
  output logic [WDATA_W-1:0]     sram_wdata,
  input  logic [RDATA_W-1:0]     sram_rdata,
  input  logic                   mem_resp
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  arb_state_t          state_q, state_d;
  mem_op_t             op_q, op_d;
  logic                ptr_q, ptr_d, gid_q, gid_d;
  logic                re_q, re_d, we_q, we_d, busy_q, busy_d;
  logic [1:0]          done_q, done_d, err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WDATA_W-1:0]  wdata_q, wdata_d;
  logic [RDATA_W-1:0]  rdata_q, rdata_d;
  logic [1:0]          req;
  logic                pick_valid, pick_id;
  assign req = rd_req | wr_req;
  sram_rr_pick u_pick (
    .req       (req),
    .ptr       (ptr_q),
    .gnt_valid (pick_valid),
    .gnt_id    (pick_id)
  );
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    done_d  = '0;
    err_d   = '0;
    rdata_d = '0;
    re_d    = 1'b0;
    we_d    = 1'b0;
    case (state_q)
      ARB_IDLE: if (pick_valid) begin
        state_d = ARB_BUSY;
        gid_d   = pick_id;
        op_d    = wr_req[pick_id] ? MEM_WR : MEM_RD;
        addr_d  = addr_in[pick_id];
        wdata_d = wdata_in[pick_id];
        cnt_d   = '0;
        re_d    = op_d == MEM_RD;
        we_d    = op_d == MEM_WR;
      end
      ARB_BUSY: if (mem_resp || cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
        state_d = ARB_RESP;
        done_d  = gid_q ? 2'b10 : 2'b01;
        err_d   = mem_resp ? 2'b00 : done_d;
        rdata_d = (mem_resp && op_q == MEM_RD) ? sram_rdata : '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
        re_d  = op_q == MEM_RD;
        we_d  = op_q == MEM_WR;
      end
      ARB_RESP: begin
        state_d = ARB_IDLE;
        ptr_d   = ~gid_q;
      end
      default: state_d = ARB_IDLE;
    endcase
    busy_d = state_d != ARB_IDLE;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ARB_IDLE;
      op_q    <= MEM_RD;
      ptr_q   <= 1'b0;
      gid_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      rdata_q <= '0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      re_q    <= re_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
    end
  end
  assign done       = done_q;
  assign err        = err_q;
  assign rdata_out  = rdata_q;
  assign grant_id   = gid_q;
  assign busy       = busy_q;
  assign sram_re    = re_q;
  assign sram_we    = we_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: scoreboard bench with a behavioural SRAM and per-port in-order expectations
module tb_sram_port_arbiter;
  typedef struct {
    bit          wr;
    logic [13:0] a;
    logic [15:0] d;
    int          lat;
    logic [7:0]  rdata;
    bit          err;
  } txn_t;
  logic clk, reset_n;
  logic rd0, rd1, wr0, wr1;
  logic [13:0] a0, a1;
  logic [15:0] d0, d1;
  int lat0, lat1;
  logic [1:0] rd_req, wr_req, done, err;
  logic [1:0][13:0] addr_in;
  logic [1:0][15:0] wdata_in;
  logic [7:0] rdata_out, sram_rdata;
  logic grant_id, busy, sram_re, sram_we, mem_resp;
  logic [13:0] sram_addr;
  logic [15:0] sram_wdata;
  logic [15:0] mem [0:16383];
  logic [15:0] shadow [0:16383];
  txn_t q0[$], q1[$];
  int order[$];
  int errors = 0, checks = 0;
  bit stray = 0;
  assign rd_req   = {rd1, rd0};
  assign wr_req   = {wr1, wr0};
  assign addr_in  = {a1, a0};
  assign wdata_in = {d1, d0};
  sram_port_arbiter dut (
    .clk(clk), .reset_n(reset_n), .rd_req(rd_req), .wr_req(wr_req),
    .addr_in(addr_in), .wdata_in(wdata_in), .done(done), .err(err),
    .rdata_out(rdata_out), .grant_id(grant_id), .busy(busy),
    .sram_re(sram_re), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .mem_resp(mem_resp)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Expected response is fixed when the request is issued: ports own disjoint halves of memory.
  task automatic do_txn(input int p, input bit wr, input bit both, input logic [13:0] a,
                        input logic [15:0] d, input int lat);
    txn_t t;
    int k;
    t.wr = wr; t.a = a; t.d = d; t.lat = lat; t.err = (lat == 0);
    t.rdata = (!wr && lat != 0) ? shadow[a][7:0] : 8'h00;
    if (wr && lat != 0) shadow[a] = d;
    if (p == 0) begin
      q0.push_back(t); lat0 = lat; a0 = a; d0 = d; wr0 = wr; rd0 = !wr | both;
    end else begin
      q1.push_back(t); lat1 = lat; a1 = a; d1 = d; wr1 = wr; rd1 = !wr | both;
    end
    k = 0;
    while (!done[p] && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 300) chk("wait_done_timeout", p, 99);
    @(posedge clk); #1;
    if (p == 0) begin rd0 = 0; wr0 = 0; end else begin rd1 = 0; wr1 = 0; end
  endtask
  task automatic rand_port(input int p, input int n, input int max_gap);
    int g, lat;
    bit wr, both;
    logic [13:0] a;
    for (int i = 0; i < n; i++) begin
      g = $urandom_range(0, max_gap);
      repeat (g) begin @(posedge clk); #1; end
      wr   = 1'($urandom_range(0, 1));
      both = 1'($urandom_range(0, 1));
      lat  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 5);
      a    = {p[0], 13'($urandom_range(0, 31))};
      do_txn(p, wr, both, a, 16'($urandom), lat);
    end
  endtask
  // Behavioural SRAM: answers after the port's chosen number of strobe cycles, 0 means never.
  initial begin
    int scnt, slat;
    scnt = 0; slat = 0;
    mem_resp = 0; sram_rdata = 0;
    forever begin
      @(posedge clk); #1;
      mem_resp = 0;
      sram_rdata = 8'($urandom);
      if (!(sram_re | sram_we)) begin
        scnt = 0;
        if (stray) begin mem_resp = 1; sram_rdata = 8'h5A; stray = 0; end
      end else begin
        if (scnt == 0) slat = sram_addr[13] ? lat1 : lat0;
        scnt++;
        if (slat != 0 && scnt == slat) begin
          mem_resp = 1;
          sram_rdata = mem[sram_addr][7:0];
          if (sram_we) mem[sram_addr] = sram_wdata;
        end
      end
    end
  end
  initial begin
    int cyc, resp_cyc, scnt, p;
    bit s_we, s_gid, stable, have;
    logic [13:0] s_a;
    logic [15:0] s_d;
    txn_t t;
    cyc = 0; resp_cyc = 0; scnt = 0; s_we = 0; s_gid = 0; stable = 1; s_a = 0; s_d = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) scnt = 0;
      else begin
        if (sram_re | sram_we) begin
          chk("strobe_exclusive", {31'd0, sram_re & sram_we}, 0);
          if (scnt == 0) begin
            s_we = sram_we; s_a = sram_addr; s_d = sram_wdata; s_gid = grant_id; stable = 1;
          end else if (sram_we != s_we || sram_addr != s_a || sram_wdata != s_d) stable = 0;
          scnt++;
          if (mem_resp) resp_cyc = cyc;
        end
        if (done != 0) begin
          p = done[1] ? 1 : 0;
          chk("done_onehot", done, p ? 2 : 1);
          have = 0;
          if (p == 0 && q0.size() > 0) begin t = q0.pop_front(); have = 1; end
          else if (p == 1 && q1.size() > 0) begin t = q1.pop_front(); have = 1; end
          chk("done_expected", have, 1);
          if (have) begin
            chk("err", err, t.err ? (p ? 2 : 1) : 0);
            chk("rdata", rdata_out, t.rdata);
            chk("op", s_we, t.wr);
            chk("addr", s_a, t.a);
            if (t.wr) chk("wdata", s_d, t.d);
            chk("grant_id", s_gid, p);
            chk("strobe_stable", stable, 1);
            chk("strobe_cycles", scnt, t.err ? 64 : t.lat);
            if (!t.err) chk("resp_to_done", cyc - resp_cyc, 1);
            chk("busy_at_done", busy, 1);
          end
          order.push_back(p);
          scnt = 0;
        end
      end
    end
  end
  initial begin
    logic [15:0] v;
    rd0 = 0; rd1 = 0; wr0 = 0; wr1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0; lat0 = 1; lat1 = 1;
    for (int i = 0; i < 16384; i++) begin
      v = 16'($urandom);
      mem[i] = v; shadow[i] = v;
    end
    mem[14'h0123] = 16'h00A5; shadow[14'h0123] = 16'h00A5;
    reset_n = 1;
    #1 reset_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata_out, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_re", sram_re, 0);
    chk("rst_we", sram_we, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_wdata", sram_wdata, 0);
    reset_n = 1;
    @(posedge clk); #1;
    order.delete();
    fork
      rand_port(0, 3, 0);
      rand_port(1, 3, 0);
    join
    chk("contention_count", order.size(), 6);
    for (int i = 0; i < 6 && i < order.size(); i++) chk("contention_order", order[i], i % 2);
    do_txn(0, 0, 0, 14'h0123, 16'h0000, 3);
    do_txn(1, 1, 0, 14'h3FFF, 16'hBEEF, 2);
    chk("sram_write_bef", mem[14'h3FFF], 16'hBEEF);
    do_txn(0, 0, 0, 14'h0055, 16'h0000, 0);
    do_txn(0, 0, 0, 14'h0055, 16'h0000, 2);
    stray = 1;
    repeat (3) begin @(posedge clk); #1; end
    chk("stray_idle", busy, 0);
    do_txn(1, 1, 1, 14'h2010, 16'h1234, 3);
    do_txn(1, 0, 0, 14'h2010, 16'h0000, 1);
    fork
      rand_port(0, 20, 4);
      rand_port(1, 20, 4);
    join
    a0 = 14'h0042; rd0 = 1; lat0 = 0;
    repeat (5) begin @(posedge clk); #1; end
    chk("busy_before_reset", busy, 1);
    #2 reset_n = 0;
    #1;
    chk("midrst_re", sram_re, 0);
    chk("midrst_we", sram_we, 0);
    chk("midrst_done", done, 0);
    chk("midrst_err", err, 0);
    chk("midrst_busy", busy, 0);
    rd0 = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    @(posedge clk); #1;
    order.delete();
    fork
      rand_port(0, 1, 0);
      rand_port(1, 1, 0);
    join
    chk("post_reset_count", order.size(), 2);
    if (order.size() == 2) begin
      chk("post_reset_first", order[0], 0);
      chk("post_reset_second", order[1], 1);
    end
    chk("leftover_q0", q0.size(), 0);
    chk("leftover_q1", q1.size(), 0);
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
